// File: rtl/snk68_pkg.sv
// Shared constants and helpers for the SNK68 68000 <-> Z80 sound command path.
package snk68_pkg;

    typedef logic [0:0] nmi_state_t;

    localparam nmi_state_t NMI_IDLE  = 1'b0;
    localparam nmi_state_t NMI_PULSE = 1'b1;

    localparam logic [23:0] M68K_LATCH_ADDR = 24'h080000;
    localparam logic [23:0] M68K_REPLY_ADDR = 24'h0F8000;
    localparam logic [15:0] Z80_LATCH_ADDR  = 16'hF800;

    localparam int unsigned NMI_WIDTH_DEFAULT = 16;

    function automatic logic [7:0] lane_select(input logic [15:0] data, input bit byte_hi);
        return byte_hi ? data[15:8] : data[7:0];
    endfunction

    function automatic logic [15:0] lane_place(input logic [7:0] data, input bit byte_hi);
        return byte_hi ? {data, 8'h00} : {8'h00, data};
    endfunction

endpackage

// File: rtl/snk68_strobe_edge.sv
// Turns a level strobe into a one-clock event on its rising or falling edge.
module snk68_strobe_edge #(
    parameter bit RISE = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe,
    output logic pulse
);

    logic hist_q;
    logic primed_q;

    // The first cycle after reset only loads the history, so a strobe already
    // asserted across reset release never looks like an edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist_q   <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            hist_q   <= strobe;
            primed_q <= 1'b1;
        end
    end

    assign pulse = primed_q & (RISE ? (strobe & ~hist_q) : (~strobe & hist_q));

endmodule

// File: rtl/snk68_sound_latch.sv
// Bidirectional 68000 <-> Z80 sound command latches with NMI generation and status.
module snk68_sound_latch
    import snk68_pkg::*;
#(
    parameter int unsigned NMI_WIDTH    = NMI_WIDTH_DEFAULT,
    parameter bit          M68K_BYTE_HI = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m68k_latch_cs,
    input  logic        z80_latch_read_cs,
    input  logic [15:0] m68k_dout,
    output logic [15:0] m68k_latch_din,
    input  logic        z80_latch_cs,
    input  logic        z80_rd_n,
    input  logic        z80_wr_n,
    input  logic [7:0]  z80_dout,
    output logic [7:0]  z80_latch_dout,
    output logic        z80_nmi_n,
    output logic        cmd_pending,
    output logic        reply_pending,
    output logic        cmd_overrun
);

    localparam logic [7:0] NMI_RELOAD = 8'(NMI_WIDTH - 1);

    logic m68k_wr_ev, m68k_rd_ev, z80_wr_ev, z80_rd_ev;

    snk68_strobe_edge #(.RISE(1'b1)) u_m68k_wr (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (m68k_latch_cs),
        .pulse   (m68k_wr_ev)
    );

    // Reads complete on the falling edge so the data holds for the whole access.
    snk68_strobe_edge #(.RISE(1'b0)) u_m68k_rd (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (z80_latch_read_cs),
        .pulse   (m68k_rd_ev)
    );

    snk68_strobe_edge #(.RISE(1'b1)) u_z80_wr (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (z80_latch_cs & ~z80_wr_n),
        .pulse   (z80_wr_ev)
    );

    snk68_strobe_edge #(.RISE(1'b0)) u_z80_rd (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (z80_latch_cs & ~z80_rd_n),
        .pulse   (z80_rd_ev)
    );

    logic [7:0] soundlatch_q, soundlatch_d;
    logic [7:0] soundlatch2_q, soundlatch2_d;
    logic       cmd_pending_q, cmd_pending_d;
    logic       reply_pending_q, reply_pending_d;
    logic       cmd_overrun_q, cmd_overrun_d;
    nmi_state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       nmi_n_q, nmi_n_d;

    always_comb begin
        soundlatch_d    = soundlatch_q;
        soundlatch2_d   = soundlatch2_q;
        cmd_pending_d   = cmd_pending_q;
        reply_pending_d = reply_pending_q;
        cmd_overrun_d   = cmd_overrun_q;

        // Writes are applied after reads so a same-cycle write wins.
        if (z80_rd_ev) cmd_pending_d = 1'b0;
        if (m68k_wr_ev) begin
            soundlatch_d  = lane_select(m68k_dout, M68K_BYTE_HI);
            cmd_pending_d = 1'b1;
            if (cmd_pending_q) cmd_overrun_d = 1'b1;
        end

        if (m68k_rd_ev) reply_pending_d = 1'b0;
        if (z80_wr_ev) begin
            soundlatch2_d   = z80_dout;
            reply_pending_d = 1'b1;
        end
    end

    // A write during a pulse just reloads the counter, so the Z80 sees one NMI edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nmi_n_d = nmi_n_q;
        if (m68k_wr_ev) begin
            state_d = NMI_PULSE;
            cnt_d   = NMI_RELOAD;
            nmi_n_d = 1'b0;
        end else begin
            unique case (state_q)
                NMI_PULSE: begin
                    if (cnt_q == 8'd0) begin
                        state_d = NMI_IDLE;
                        nmi_n_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            soundlatch_q    <= 8'h00;
            soundlatch2_q   <= 8'h00;
            cmd_pending_q   <= 1'b0;
            reply_pending_q <= 1'b0;
            cmd_overrun_q   <= 1'b0;
            state_q         <= NMI_IDLE;
            cnt_q           <= 8'd0;
            nmi_n_q         <= 1'b1;
        end else begin
            soundlatch_q    <= soundlatch_d;
            soundlatch2_q   <= soundlatch2_d;
            cmd_pending_q   <= cmd_pending_d;
            reply_pending_q <= reply_pending_d;
            cmd_overrun_q   <= cmd_overrun_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            nmi_n_q         <= nmi_n_d;
        end
    end

    assign z80_latch_dout = soundlatch_q;
    assign m68k_latch_din = lane_place(soundlatch2_q, M68K_BYTE_HI);
    assign z80_nmi_n      = nmi_n_q;
    assign cmd_pending    = cmd_pending_q;
    assign reply_pending  = reply_pending_q;
    assign cmd_overrun    = cmd_overrun_q;

endmodule

// File: tb/tb_snk68_sound_latch.sv
// Bench for snk68_sound_latch: directed vector table, corner sequences, random vs. model.
module tb_snk68_sound_latch;

    localparam int NMI_W = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m68k_latch_cs;
    logic        z80_latch_read_cs;
    logic [15:0] m68k_dout;
    logic [15:0] m68k_latch_din;
    logic        z80_latch_cs;
    logic        z80_rd_n;
    logic        z80_wr_n;
    logic [7:0]  z80_dout;
    logic [7:0]  z80_latch_dout;
    logic        z80_nmi_n;
    logic        cmd_pending;
    logic        reply_pending;
    logic        cmd_overrun;

    always #5 clk = ~clk;

    snk68_sound_latch #(
        .NMI_WIDTH    (NMI_W),
        .M68K_BYTE_HI (1'b1)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .m68k_latch_cs     (m68k_latch_cs),
        .z80_latch_read_cs (z80_latch_read_cs),
        .m68k_dout         (m68k_dout),
        .m68k_latch_din    (m68k_latch_din),
        .z80_latch_cs      (z80_latch_cs),
        .z80_rd_n          (z80_rd_n),
        .z80_wr_n          (z80_wr_n),
        .z80_dout          (z80_dout),
        .z80_latch_dout    (z80_latch_dout),
        .z80_nmi_n         (z80_nmi_n),
        .cmd_pending       (cmd_pending),
        .reply_pending     (reply_pending),
        .cmd_overrun       (cmd_overrun)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: latch contents, flags, and cycles of NMI low still owed.
    logic [7:0] m_sl, m_sl2;
    bit         m_cp, m_rp, m_ov, m_primed;
    int         m_rem;
    bit         p_w68, p_r68, p_zw, p_zr;

    // NMI waveform tracking for the corner sequences.
    int nlow, falls;
    bit prev_nmi;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        bit s_zw, s_zr, ev_w, ev_r68, ev_zw, ev_zr, old_cp;
        s_zw = z80_latch_cs & ~z80_wr_n;
        s_zr = z80_latch_cs & ~z80_rd_n;
        if (!reset_n) begin
            m_sl = 8'h00; m_sl2 = 8'h00;
            m_cp = 0; m_rp = 0; m_ov = 0; m_rem = 0;
            m_primed = 0; p_w68 = 0; p_r68 = 0; p_zw = 0; p_zr = 0;
        end else begin
            ev_w   = m_primed && m68k_latch_cs && !p_w68;
            ev_r68 = m_primed && !z80_latch_read_cs && p_r68;
            ev_zw  = m_primed && s_zw && !p_zw;
            ev_zr  = m_primed && !s_zr && p_zr;
            old_cp = m_cp;
            if (ev_zr) m_cp = 0;
            if (ev_w) begin
                m_sl = m68k_dout[15:8];
                m_cp = 1;
                if (old_cp) m_ov = 1;
                m_rem = NMI_W;
            end else if (m_rem > 0) begin
                m_rem--;
            end
            if (ev_r68) m_rp = 0;
            if (ev_zw) begin
                m_sl2 = z80_dout;
                m_rp  = 1;
            end
            m_primed = 1;
            p_w68 = m68k_latch_cs; p_r68 = z80_latch_read_cs; p_zw = s_zw; p_zr = s_zr;
        end
        @(posedge clk);
        #1;
        check("model nmi_n", 16'(z80_nmi_n), 16'(m_rem == 0));
        check("model cmd_pending", 16'(cmd_pending), 16'(m_cp));
        check("model reply_pending", 16'(reply_pending), 16'(m_rp));
        check("model cmd_overrun", 16'(cmd_overrun), 16'(m_ov));
        check("model z80_latch_dout", 16'(z80_latch_dout), 16'(m_sl));
        check("model m68k_latch_din", m68k_latch_din, {m_sl2, 8'h00});
        if (!z80_nmi_n) nlow++;
        if (prev_nmi && !z80_nmi_n) falls++;
        prev_nmi = z80_nmi_n;
    endtask

    task automatic idle_inputs();
        m68k_latch_cs = 0; z80_latch_read_cs = 0; m68k_dout = 16'h0000;
        z80_latch_cs = 0; z80_rd_n = 1; z80_wr_n = 1; z80_dout = 8'h00;
    endtask

    task automatic do_reset();
        reset_n = 0;
        idle_inputs();
        cycle();
        cycle();
        reset_n = 1;
        cycle();
        nlow = 0; falls = 0; prev_nmi = 1;
    endtask

    task automatic m68k_write(input logic [7:0] b);
        m68k_latch_cs = 1; m68k_dout = {b, 8'h5A};
        cycle();
        m68k_latch_cs = 0;
    endtask

    typedef struct {
        logic        m_cs;
        logic        rd_cs;
        logic [15:0] dout;
        logic        z_cs;
        logic        z_rd_n;
        logic        z_wr_n;
        logic [7:0]  z_dout;
        logic        nmi_n;
        logic        cp;
        logic        rp;
        logic        ov;
        logic [7:0]  zl;
        logic [15:0] din;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{0, 0, 16'h0000, 0, 1, 1, 8'h00, 1, 0, 0, 0, 8'h00, 16'h0000};
        vecs[1]  = '{1, 0, 16'hA5FF, 0, 1, 1, 8'h00, 0, 1, 0, 0, 8'hA5, 16'h0000};
        vecs[2]  = '{1, 0, 16'hA5FF, 0, 1, 1, 8'h00, 0, 1, 0, 0, 8'hA5, 16'h0000};
        vecs[3]  = '{1, 0, 16'h12FF, 0, 1, 1, 8'h00, 0, 1, 0, 0, 8'hA5, 16'h0000};
        vecs[4]  = '{0, 0, 16'h0000, 0, 1, 1, 8'h00, 0, 1, 0, 0, 8'hA5, 16'h0000};
        vecs[5]  = '{0, 0, 16'h0000, 1, 0, 1, 8'h00, 0, 1, 0, 0, 8'hA5, 16'h0000};
        vecs[6]  = '{0, 0, 16'h0000, 1, 0, 1, 8'h00, 0, 1, 0, 0, 8'hA5, 16'h0000};
        vecs[7]  = '{0, 0, 16'h0000, 0, 1, 1, 8'h00, 0, 0, 0, 0, 8'hA5, 16'h0000};
        vecs[8]  = '{0, 0, 16'h0000, 1, 1, 0, 8'h3C, 0, 0, 1, 0, 8'hA5, 16'h3C00};
        vecs[9]  = '{0, 0, 16'h0000, 0, 1, 1, 8'h00, 0, 0, 1, 0, 8'hA5, 16'h3C00};
        vecs[10] = '{0, 1, 16'h0000, 0, 1, 1, 8'h00, 0, 0, 1, 0, 8'hA5, 16'h3C00};
        vecs[11] = '{0, 0, 16'h0000, 0, 1, 1, 8'h00, 0, 0, 0, 0, 8'hA5, 16'h3C00};
        vecs[12] = '{1, 0, 16'h7700, 0, 1, 1, 8'h00, 0, 1, 0, 0, 8'h77, 16'h3C00};

        // Directed table: forward write, Z80 read, Z80 reply, 68000 read.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            m68k_latch_cs = vecs[i].m_cs; z80_latch_read_cs = vecs[i].rd_cs;
            m68k_dout = vecs[i].dout; z80_latch_cs = vecs[i].z_cs;
            z80_rd_n = vecs[i].z_rd_n; z80_wr_n = vecs[i].z_wr_n; z80_dout = vecs[i].z_dout;
            cycle();
            check($sformatf("vec%0d nmi_n", i), 16'(z80_nmi_n), 16'(vecs[i].nmi_n));
            check($sformatf("vec%0d cmd_pending", i), 16'(cmd_pending), 16'(vecs[i].cp));
            check($sformatf("vec%0d reply_pending", i), 16'(reply_pending), 16'(vecs[i].rp));
            check($sformatf("vec%0d cmd_overrun", i), 16'(cmd_overrun), 16'(vecs[i].ov));
            check($sformatf("vec%0d z80_latch_dout", i), 16'(z80_latch_dout), 16'(vecs[i].zl));
            check($sformatf("vec%0d m68k_latch_din", i), m68k_latch_din, vecs[i].din);
        end

        // Single write with a 3-clk strobe gives one NMI of exactly NMI_W clocks.
        do_reset();
        m68k_latch_cs = 1; m68k_dout = 16'hA500;
        cycle(); cycle(); cycle();
        idle_inputs();
        for (int i = 0; i < 40; i++) cycle();
        check("single nmi low clocks", 16'(nlow), 16'(NMI_W));
        check("single nmi falling edges", 16'(falls), 16'd1);

        // Two writes 5 clocks apart: one stretched pulse, overrun, last byte kept.
        do_reset();
        m68k_write(8'h11);
        for (int i = 0; i < 4; i++) cycle();
        m68k_write(8'h22);
        for (int i = 0; i < 40; i++) cycle();
        check("overrun nmi low clocks", 16'(nlow), 16'(NMI_W + 5));
        check("overrun nmi falling edges", 16'(falls), 16'd1);
        check("overrun latch", 16'(z80_latch_dout), 16'h0022);
        check("overrun flag", 16'(cmd_overrun), 16'd1);

        // Retrigger on the very clock the pulse would end: no high gap.
        do_reset();
        m68k_write(8'h31);
        for (int i = 0; i < NMI_W - 1; i++) cycle();
        m68k_write(8'h32);
        for (int i = 0; i < 40; i++) cycle();
        check("retrigger nmi low clocks", 16'(nlow), 16'(2 * NMI_W));
        check("retrigger nmi falling edges", 16'(falls), 16'd1);

        // Z80 read completing in the same clock as a new 68000 write: write wins.
        do_reset();
        m68k_write(8'h55);
        z80_latch_cs = 1; z80_rd_n = 0;
        cycle(); cycle();
        z80_latch_cs = 0; z80_rd_n = 1;
        m68k_latch_cs = 1; m68k_dout = 16'h6600;
        cycle();
        check("same-clk cmd_pending", 16'(cmd_pending), 16'd1);
        check("same-clk latch", 16'(z80_latch_dout), 16'h0066);
        idle_inputs();
        cycle();

        // Reset mid-pulse with the write strobe held across release.
        do_reset();
        m68k_latch_cs = 1; m68k_dout = 16'h9900;
        cycle(); cycle(); cycle();
        reset_n = 0;
        cycle();
        check("reset nmi_n", 16'(z80_nmi_n), 16'd1);
        cycle();
        reset_n = 1;
        nlow = 0; falls = 0; prev_nmi = z80_nmi_n;
        for (int i = 0; i < 5; i++) cycle();
        idle_inputs();
        for (int i = 0; i < 20; i++) cycle();
        check("post-reset nmi low clocks", 16'(nlow), 16'd0);
        check("post-reset cmd_pending", 16'(cmd_pending), 16'd0);
        check("post-reset overrun", 16'(cmd_overrun), 16'd0);
        check("post-reset latch", 16'(z80_latch_dout), 16'h0000);

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) == 0) m68k_latch_cs = ~m68k_latch_cs;
            if ($urandom_range(0, 3) == 0) z80_latch_read_cs = ~z80_latch_read_cs;
            if ($urandom_range(0, 3) == 0) z80_latch_cs = ~z80_latch_cs;
            if ($urandom_range(0, 3) == 0) z80_rd_n = ~z80_rd_n;
            if ($urandom_range(0, 3) == 0) z80_wr_n = ~z80_wr_n;
            m68k_dout = 16'($urandom);
            z80_dout  = 8'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snk68_sound_latch.md
Name: snk68_sound_latch

Overview:
- Bidirectional command path between the 68000 and the Z80 sound CPU. It consumes the latch chip-selects from the address decoder.
- Forward path: the 68000 writes a command byte into soundlatch. The block then raises a Z80 NMI, and the Z80 reads the byte back at 0xF800.
- Reverse path: the Z80 writes a reply byte into soundlatch2 at 0xF800, and the 68000 reads it at 0x0F8000.
- The block also resolves multi-cycle bus strobes into single-cycle events and tracks pending and overrun status.

Parameters:
- NMI_WIDTH, 16: clk cycles that z80_nmi_n is held low per 68000 command write (1..255).
- M68K_BYTE_HI, 1: 1 = the 68000 command and reply bytes travel on D15:8 (even byte address); 0 = on D7:0.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- m68k_latch_cs  in  1  68000 write strobe to soundlatch (decoder already qualifies with !rw and !as_n)
- z80_latch_read_cs  in  1  68000 read strobe for soundlatch2
- m68k_dout  in  16  68000 write data bus
- m68k_latch_din  out  16  soundlatch2 value placed on the selected byte lane; other lane 0
- z80_latch_cs  in  1  Z80 MREQ access at 0xF800
- z80_rd_n  in  1  Z80 read strobe
- z80_wr_n  in  1  Z80 write strobe
- z80_dout  in  8  Z80 write data
- z80_latch_dout  out  8  soundlatch value to Z80
- z80_nmi_n  out  1  Z80 NMI, active low
- cmd_pending  out  1  soundlatch written and not yet read by the Z80
- reply_pending  out  1  soundlatch2 written and not yet read by the 68000
- cmd_overrun  out  1  sticky: a 68000 write landed while cmd_pending was set

Behaviour:
- Reset values: all latches = 0x00, z80_nmi_n = 1, all pending and overrun flags = 0, NMI counter = 0, edge-detect history = 0.
- Strobe qualification:
  - m68k_wr_ev = rising edge of m68k_latch_cs (registered previous value).
  - m68k_rd_ev = falling edge of z80_latch_read_cs, so the data stays stable for the whole read.
  - z80_wr_ev = rising edge of (z80_latch_cs & !z80_wr_n).
  - z80_rd_ev = falling edge of (z80_latch_cs & !z80_rd_n).
  - Each event lasts exactly one clk, however long the strobe is held.
- On m68k_wr_ev:
  - soundlatch <= selected byte of m68k_dout; visible on z80_latch_dout the next cycle.
  - cmd_pending <= 1.
  - If cmd_pending was already 1, cmd_overrun <= 1.
  - NMI FSM: IDLE -> PULSE, z80_nmi_n <= 0, counter <= NMI_WIDTH-1.
- NMI FSM (two states, IDLE and PULSE):
  - In PULSE the counter decrements each clk; at 0 -> IDLE and z80_nmi_n <= 1.
  - An m68k_wr_ev during PULSE reloads the counter and stays in PULSE. It does not produce an extra edge; the Z80 sees one NMI.
  - An m68k_wr_ev in the same cycle as the counter reaching 0 takes priority: the FSM stays in PULSE and reloads.
  - Minimum high time between pulses = 1 clk.
- On z80_rd_ev: cmd_pending <= 0. z80_latch_dout is combinationally the soundlatch register (no read latency).
- On z80_wr_ev: soundlatch2 <= z80_dout, reply_pending <= 1.
- On m68k_rd_ev: reply_pending <= 0. m68k_latch_din always drives soundlatch2 on the lane selected by M68K_BYTE_HI.
- Simultaneous events:
  - Write and read of the same latch in one cycle: the write wins, so the pending flag is set and the new data is stored.
  - The forward and reverse paths are fully independent.
- cmd_overrun is cleared only by reset.
- Reset asserted mid-pulse: z80_nmi_n returns to 1 on the next clk edge and the FSM goes to IDLE.
- Strobes held high through reset release: they must not generate an event. The edge history is initialised from the current strobe level in the first cycle after reset.

Decomposition:
- Shared package snk68_pkg holds:
  - NMI FSM state enum (NMI_IDLE, NMI_PULSE);
  - latch address constants (M68K_LATCH_ADDR 0x080000, M68K_REPLY_ADDR 0x0F8000, Z80_LATCH_ADDR 0xF800);
  - default NMI_WIDTH.
- One natural sub-module, snk68_strobe_edge: a parameterised rise/fall single-cycle event generator with reset-safe history. It is instantiated four times.

Test Plan:
- 68000 write, 0xA5 on D15:8, m68k_latch_cs high for 3 clk -> soundlatch = 0xA5 one cycle after the rise; cmd_pending = 1; z80_nmi_n low for exactly 16 clk, once.
- Z80 reads 0xF800 (z80_rd_n low for 4 clk) -> z80_latch_dout = 0xA5 throughout; cmd_pending clears on the cycle after the strobe falls.
- Z80 writes 0x3C at 0xF800, then the 68000 reads 0x0F8000 -> m68k_latch_din = 0x3C00; reply_pending goes 1, then 0 after the read strobe falls.
- Two 68000 writes (0x11 at t0, 0x22 at t0+5) with no Z80 read in between -> soundlatch = 0x22; cmd_overrun = 1; z80_nmi_n continuously low from t0+1 to t0+21 (single falling edge).
- Z80 read event and 68000 write event in the same clk -> cmd_pending stays 1; the new byte is latched.
- reset_n low during an NMI pulse with m68k_latch_cs held high across release -> z80_nmi_n = 1; no new pulse; all flags 0 after release.
